// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle control unit.
//   - stateT: 6-bit FSM state encoding (also exported on the State debug port)
//   - opcode / funct codes of the supported MIPS subset
//   - 2-bit encodings for the OrigPC, MemparaReg, OrigBALU and OpALU selects
//   - decodeIr: maps IR[31:26] / IR[5:0] to the state that follows IR_WRITE
package ctrl_pkg;

  typedef enum logic [5:0] {
    S_FETCH       = 6'd0,
    S_FETCH_WAIT  = 6'd1,
    S_IR_WRITE    = 6'd2,
    S_CLASSE_R    = 6'd3,
    S_WRITE_RD    = 6'd4,
    S_ADDI        = 6'd5,
    S_ADDI_WB     = 6'd6,
    S_REF_MEM     = 6'd7,
    S_LOAD        = 6'd8,
    S_LOAD_WAIT   = 6'd9,
    S_END_REF_MEM = 6'd10,
    S_STORE       = 6'd11,
    S_STORE_WAIT  = 6'd12,
    S_BEQ         = 6'd13,
    S_BNE         = 6'd14,
    S_LUI         = 6'd15,
    S_JUMP        = 6'd16,
    S_NOP         = 6'd17,
    S_BREAK       = 6'd18,
    S_EXC         = 6'd19
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_BREAK = 6'h0d;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  localparam logic [1:0] ORIGPC_ALU    = 2'b00;  // PC + 4
  localparam logic [1:0] ORIGPC_ALUOUT = 2'b01;  // branch target
  localparam logic [1:0] ORIGPC_JUMP   = 2'b10;
  localparam logic [1:0] ORIGPC_EXC    = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_LUI    = 2'b10;

  localparam logic [1:0] BALU_REG   = 2'b00;
  localparam logic [1:0] BALU_FOUR  = 2'b01;
  localparam logic [1:0] BALU_IMM   = 2'b10;
  localparam logic [1:0] BALU_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Anything not recognised lands in S_EXC (invalid opcode).
  function automatic stateT decodeIr(input logic [5:0] op, input logic [5:0] fn);
    stateT s;
    s = S_EXC;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_NOP:                                s = S_NOP;
          FN_BREAK:                              s = S_BREAK;
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: s = S_CLASSE_R;
          default:                               s = S_EXC;
        endcase
      end
      OP_J:         s = S_JUMP;
      OP_BEQ:       s = S_BEQ;
      OP_BNE:       s = S_BNE;
      OP_ADDI:      s = S_ADDI;
      OP_LUI:       s = S_LUI;
      OP_LW, OP_SW: s = S_REF_MEM;
      default:      s = S_EXC;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// mem_wait_cnt: loadable down-counter timing the memory wait states.
//   clock  in   system clock
//   reset  in   asynchronous, active-low
//   load   in   reload with MEM_WAIT-1 (asserted in the state before a wait state)
//   done   out  count reached zero: the current wait cycle is the last one
module mem_wait_cnt #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int unsigned CW = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] LOAD_VAL = (MEM_WAIT == 0) ? '0 : CW'(MEM_WAIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/unidade_controle_mc.sv
// unidade_controle_mc: multicycle control unit for the MIPS-subset datapath.
//   clock, reset (async, active-low)
//   OPcode, funct      IR fields; Overflow  ALU overflow flag
//   Escreve*           write enables for PC, regs, memory, IR, MDR, ALUOut, EPC, cause
//   IouD, RegDst, OrigAALU, OrigPC, MemparaReg, OrigBALU, OpALU   datapath selects
//   Causa              0 = invalid opcode, 1 = overflow (valid in EXC)
//   Halted             high in BREAK;  State  current state, for debug
//
// state        | meaning
// FETCH        | read instruction, PC <= PC + 4
// FETCH_WAIT   | instruction memory wait states
// IR_WRITE     | latch IR, precompute branch target, decode
// CLASSE_R     | R-type ALU operation
// WRITE_RD     | R-type write-back to rd
// ADDI         | immediate add
// ADDI_WB      | ADDI write-back to rt
// REF_MEM      | load/store address computation
// LOAD         | data memory read
// LOAD_WAIT    | data memory read wait states
// END_REF_MEM  | load write-back
// STORE        | data memory write
// STORE_WAIT   | data memory write wait states
// BEQ / BNE    | conditional branch
// LUI          | load upper immediate
// JUMP         | jump
// NOP          | no operation
// BREAK        | halted until reset
// EXC          | capture EPC/cause, go to exception vector
module unidade_controle_mc
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT       = 1,
  parameter logic [1:0]  EXC_VECTOR_SEL = ORIGPC_EXC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] OPcode,
  input  logic [5:0] funct,
  input  logic       Overflow,
  output logic       EscreveMem,
  output logic       EscrevePC,
  output logic       EscrevePCCondEQ,
  output logic       EscrevePCCondNE,
  output logic       EscreveReg,
  output logic       EscreveIR,
  output logic       EscreveMDR,
  output logic       EscreveAluOut,
  output logic       EscreveEPC,
  output logic       EscreveCausa,
  output logic       IouD,
  output logic       RegDst,
  output logic       OrigAALU,
  output logic [1:0] OrigPC,
  output logic [1:0] MemparaReg,
  output logic [1:0] OrigBALU,
  output logic [1:0] OpALU,
  output logic       Causa,
  output logic       Halted,
  output logic [5:0] State
);

  localparam bit HAS_WAIT = (MEM_WAIT > 0);

  stateT state, nextState;
  logic  causaReg, nextCausa;
  logic  waitLoad, waitDone;

  // Every wait state is entered only from FETCH, LOAD or STORE.
  assign waitLoad = (state == S_FETCH) || (state == S_LOAD) || (state == S_STORE);

  mem_wait_cnt #(.MEM_WAIT(MEM_WAIT)) waitCnt (
    .clock (clock),
    .reset (reset),
    .load  (waitLoad),
    .done  (waitDone)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      causaReg <= 1'b0;
    end else begin
      state    <= nextState;
      causaReg <= (nextState == S_EXC) ? nextCausa : 1'b0;
    end
  end

  always_comb begin
    nextState       = state;
    nextCausa       = 1'b0;
    EscreveMem      = 1'b0;
    EscrevePC       = 1'b0;
    EscrevePCCondEQ = 1'b0;
    EscrevePCCondNE = 1'b0;
    EscreveReg      = 1'b0;
    EscreveIR       = 1'b0;
    EscreveMDR      = 1'b0;
    EscreveAluOut   = 1'b0;
    EscreveEPC      = 1'b0;
    EscreveCausa    = 1'b0;
    IouD            = 1'b0;
    RegDst          = 1'b0;
    OrigAALU        = 1'b0;
    OrigPC          = 2'b00;
    MemparaReg      = 2'b00;
    OrigBALU        = 2'b00;
    OpALU           = 2'b00;
    Halted          = 1'b0;
    // While reset is held the state already reads FETCH, but no FETCH
    // enables may leak out until reset is released.
    if (reset) begin
      case (state)
        S_FETCH: begin
          OrigBALU  = BALU_FOUR;
          OpALU     = ALUOP_ADD;
          OrigPC    = ORIGPC_ALU;
          EscrevePC = 1'b1;
          nextState = HAS_WAIT ? S_FETCH_WAIT : S_IR_WRITE;
        end
        S_FETCH_WAIT: if (waitDone) nextState = S_IR_WRITE;
        S_IR_WRITE: begin
          EscreveIR     = 1'b1;
          EscreveAluOut = 1'b1;
          OrigBALU      = BALU_IMMSH;
          nextState     = decodeIr(OPcode, funct);
        end
        S_CLASSE_R: begin
          OrigAALU      = 1'b1;
          OrigBALU      = BALU_REG;
          OpALU         = ALUOP_FUNCT;
          EscreveAluOut = 1'b1;
          // Only the signed add/sub trap; AND/OR/SLT ignore the flag.
          if (Overflow && (funct == FN_ADD || funct == FN_SUB)) begin
            nextState = S_EXC;
            nextCausa = 1'b1;
          end else begin
            nextState = S_WRITE_RD;
          end
        end
        S_WRITE_RD: begin
          RegDst     = 1'b1;
          EscreveReg = 1'b1;
          MemparaReg = M2R_ALUOUT;
          nextState  = S_FETCH;
        end
        S_ADDI: begin
          OrigAALU      = 1'b1;
          OrigBALU      = BALU_IMM;
          OpALU         = ALUOP_ADD;
          EscreveAluOut = 1'b1;
          if (Overflow) begin
            nextState = S_EXC;
            nextCausa = 1'b1;
          end else begin
            nextState = S_ADDI_WB;
          end
        end
        S_ADDI_WB: begin
          EscreveReg = 1'b1;
          MemparaReg = M2R_ALUOUT;
          nextState  = S_FETCH;
        end
        S_REF_MEM: begin
          OrigAALU      = 1'b1;
          OrigBALU      = BALU_IMM;
          EscreveAluOut = 1'b1;
          nextState     = (OPcode == OP_SW) ? S_STORE : S_LOAD;
        end
        S_LOAD: begin
          IouD       = 1'b1;
          EscreveMDR = 1'b1;
          nextState  = HAS_WAIT ? S_LOAD_WAIT : S_END_REF_MEM;
        end
        S_LOAD_WAIT: begin
          EscreveMDR = 1'b1;
          if (waitDone) nextState = S_END_REF_MEM;
        end
        S_END_REF_MEM: begin
          MemparaReg = M2R_MDR;
          EscreveReg = 1'b1;
          nextState  = S_FETCH;
        end
        S_STORE: begin
          IouD       = 1'b1;
          EscreveMem = 1'b1;
          nextState  = HAS_WAIT ? S_STORE_WAIT : S_FETCH;
        end
        S_STORE_WAIT: if (waitDone) nextState = S_FETCH;
        S_BEQ: begin
          OrigAALU        = 1'b1;
          OpALU           = ALUOP_SUB;
          OrigPC          = ORIGPC_ALUOUT;
          EscrevePCCondEQ = 1'b1;
          nextState       = S_FETCH;
        end
        S_BNE: begin
          OrigAALU        = 1'b1;
          OpALU           = ALUOP_SUB;
          OrigPC          = ORIGPC_ALUOUT;
          EscrevePCCondNE = 1'b1;
          nextState       = S_FETCH;
        end
        S_LUI: begin
          EscreveReg = 1'b1;
          MemparaReg = M2R_LUI;
          nextState  = S_FETCH;
        end
        S_JUMP: begin
          OrigPC    = ORIGPC_JUMP;
          EscrevePC = 1'b1;
          nextState = S_FETCH;
        end
        S_NOP: nextState = S_FETCH;
        S_BREAK: begin
          Halted    = 1'b1;
          nextState = S_BREAK;
        end
        S_EXC: begin
          // PC was already advanced in FETCH; PC - 4 goes to EPC.
          OrigBALU     = BALU_FOUR;
          OpALU        = ALUOP_SUB;
          EscreveEPC   = 1'b1;
          EscreveCausa = 1'b1;
          OrigPC       = EXC_VECTOR_SEL;
          EscrevePC    = 1'b1;
          nextState    = S_FETCH;
        end
        default: nextState = S_FETCH;
      endcase
    end
  end

  assign Causa = causaReg;
  assign State = state;

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Scoreboard bench: two DUTs (MEM_WAIT=2 and MEM_WAIT=0) share the IR inputs
// and have separate resets. Each instruction pushes its hand-written per-cycle
// state sequence; a monitor pops one entry per cycle (or on demand for async
// reset checks) and compares state plus all control outputs.
module tb_unidade_controle_mc;
  import ctrl_pkg::*;

  typedef struct {
    stateT st;
    logic  causa;
    logic  inRst;
    int    tag;
    int    cyc;
  } expT;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]  resetV   = 2'b11;
  logic [5:0]  OPcode   = 6'h00;
  logic [5:0]  funct    = 6'h00;
  logic        Overflow = 1'b0;
  logic [28:0] obs [2];
  expT         sb [2][$];
  int          nChecks = 0;
  int          nFails  = 0;
  event        sampleEv;

  for (genvar g = 0; g < 2; g++) begin : gDut
    logic eMem, ePC, eEQ, eNE, eReg, eIR, eMDR, eAlu, eEPC, eCau, iouD, regDst, aAlu, cau, halt;
    logic [1:0] oPC, m2r, bAlu, opAlu;
    logic [5:0] st;
    unidade_controle_mc #(.MEM_WAIT(g == 0 ? 2 : 0), .EXC_VECTOR_SEL(2'b11)) dut (
      .clock(clock), .reset(resetV[g]), .OPcode(OPcode), .funct(funct), .Overflow(Overflow),
      .EscreveMem(eMem), .EscrevePC(ePC), .EscrevePCCondEQ(eEQ), .EscrevePCCondNE(eNE),
      .EscreveReg(eReg), .EscreveIR(eIR), .EscreveMDR(eMDR), .EscreveAluOut(eAlu),
      .EscreveEPC(eEPC), .EscreveCausa(eCau), .IouD(iouD), .RegDst(regDst), .OrigAALU(aAlu),
      .OrigPC(oPC), .MemparaReg(m2r), .OrigBALU(bAlu), .OpALU(opAlu),
      .Causa(cau), .Halted(halt), .State(st)
    );
    assign obs[g] = {st, eMem, ePC, eEQ, eNE, eReg, eIR, eMDR, eAlu, eEPC, eCau,
                     iouD, regDst, aAlu, oPC, m2r, bAlu, opAlu, cau, halt};
  end

  // Expected control word per state, straight from the output table.
  function automatic logic [22:0] expCtl(input stateT s, input logic c, input logic r);
    logic wMem, wPC, wEQ, wNE, wReg, wIR, wMDR, wAlu, wEPC, wCau, iouD, regDst, aAlu, cau, halt;
    logic [1:0] oPC, m2r, bAlu, op;
    wMem = 0; wPC = 0; wEQ = 0; wNE = 0; wReg = 0; wIR = 0; wMDR = 0; wAlu = 0;
    wEPC = 0; wCau = 0; iouD = 0; regDst = 0; aAlu = 0; cau = 0; halt = 0;
    oPC = 2'b00; m2r = 2'b00; bAlu = 2'b00; op = 2'b00;
    if (!r) begin
      case (s)
        S_FETCH:       begin bAlu = 2'b01; wPC = 1; end
        S_IR_WRITE:    begin wIR = 1; wAlu = 1; bAlu = 2'b11; end
        S_CLASSE_R:    begin aAlu = 1; op = 2'b10; wAlu = 1; end
        S_WRITE_RD:    begin regDst = 1; wReg = 1; end
        S_ADDI:        begin aAlu = 1; bAlu = 2'b10; wAlu = 1; end
        S_ADDI_WB:     wReg = 1;
        S_REF_MEM:     begin aAlu = 1; bAlu = 2'b10; wAlu = 1; end
        S_LOAD:        begin iouD = 1; wMDR = 1; end
        S_LOAD_WAIT:   wMDR = 1;
        S_END_REF_MEM: begin m2r = 2'b01; wReg = 1; end
        S_STORE:       begin iouD = 1; wMem = 1; end
        S_BEQ:         begin aAlu = 1; op = 2'b01; oPC = 2'b01; wEQ = 1; end
        S_BNE:         begin aAlu = 1; op = 2'b01; oPC = 2'b01; wNE = 1; end
        S_LUI:         begin wReg = 1; m2r = 2'b10; end
        S_JUMP:        begin oPC = 2'b10; wPC = 1; end
        S_EXC:         begin bAlu = 2'b01; op = 2'b01; wEPC = 1; wCau = 1; oPC = 2'b11; wPC = 1; cau = c; end
        S_BREAK:       halt = 1;
        default:       ;
      endcase
    end
    return {wMem, wPC, wEQ, wNE, wReg, wIR, wMDR, wAlu, wEPC, wCau,
            iouD, regDst, aAlu, oPC, m2r, bAlu, op, cau, halt};
  endfunction

  task automatic checkEntry(input int d, input expT e);
    logic [22:0] want;
    want = expCtl(e.st, e.causa, e.inRst);
    nChecks++;
    if (obs[d][28:23] !== 6'(e.st)) begin
      nFails++;
      $display("FAIL d%0d i%0d c%0d state: got %0d want %0d (%s)",
               d, e.tag, e.cyc, obs[d][28:23], e.st, e.st.name());
    end
    nChecks++;
    if (obs[d][22:0] !== want) begin
      nFails++;
      $display("FAIL d%0d i%0d c%0d ctl in %s: got %b want %b",
               d, e.tag, e.cyc, e.st.name(), obs[d][22:0], want);
    end
  endtask

  always begin : monitor
    expT e;
    @(negedge clock or sampleEv);
    for (int d = 0; d < 2; d++) begin
      if (sb[d].size() > 0) begin
        e = sb[d].pop_front();
        checkEntry(d, e);
      end
    end
  end

  task automatic pushExp(input int d, input stateT s, input logic c, input logic r,
                         input int tag, input int cyc);
    expT e;
    e.st    = s;
    e.causa = (s == S_EXC) ? c : 1'b0;
    e.inRst = r;
    e.tag   = tag;
    e.cyc   = cyc;
    sb[d].push_back(e);
  endtask

  // Called one time unit after a rising edge with the DUT in FETCH.
  // nTotal = 0 runs the natural length; otherwise truncates or pads with the last state.
  task automatic runInstr(input int d, input int tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic ovf, input logic c, input int nTotal, input int nTail,
                          input stateT t0, t1, t2, t3, t4);
    stateT full[$];
    stateT tail[5];
    stateT s;
    int    len;
    tail = '{t0, t1, t2, t3, t4};
    OPcode = op; funct = fn; Overflow = ovf;
    full.push_back(S_FETCH);
    for (int i = 0; i < (d == 0 ? 2 : 0); i++) full.push_back(S_FETCH_WAIT);
    full.push_back(S_IR_WRITE);
    for (int i = 0; i < nTail; i++) full.push_back(tail[i]);
    len = (nTotal == 0) ? full.size() : nTotal;
    for (int i = 0; i < len; i++) begin
      s = (i < full.size()) ? full[i] : full[$];
      pushExp(d, s, c, 1'b0, tag, i);
    end
    repeat (len) @(posedge clock);
    #1;
  endtask

  // Asserts reset between edges, checks the async response, then releases at edge+1.
  task automatic resetCheck(input int d, input int tag);
    resetV[d] = 1'b0;
    #1;
    pushExp(d, S_FETCH, 1'b0, 1'b1, tag, 0);
    ->sampleEv;
    repeat (2) @(posedge clock);
    #1;
    resetV[d] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 resetV = 2'b00;
    @(posedge clock);
    #1;
    pushExp(1, S_FETCH, 1'b0, 1'b1, 0, 0);
    resetCheck(0, 0);

    // MEM_WAIT = 2
    runInstr(0, 1,  OP_RTYPE, FN_ADD, 0, 0, 0, 2, S_CLASSE_R, S_WRITE_RD, S_FETCH, S_FETCH, S_FETCH);
    runInstr(0, 2,  OP_RTYPE, FN_SLT, 1, 0, 0, 2, S_CLASSE_R, S_WRITE_RD, S_FETCH, S_FETCH, S_FETCH);
    runInstr(0, 3,  OP_RTYPE, FN_SUB, 1, 1, 0, 2, S_CLASSE_R, S_EXC, S_FETCH, S_FETCH, S_FETCH);
    runInstr(0, 4,  OP_RTYPE, FN_ADD, 1, 1, 0, 2, S_CLASSE_R, S_EXC, S_FETCH, S_FETCH, S_FETCH);
    runInstr(0, 5,  OP_RTYPE, FN_AND, 1, 0, 0, 2, S_CLASSE_R, S_WRITE_RD, S_FETCH, S_FETCH, S_FETCH);
    runInstr(0, 6,  OP_ADDI, 6'h00, 0, 0, 0, 2, S_ADDI, S_ADDI_WB, S_FETCH, S_FETCH, S_FETCH);
    runInstr(0, 7,  OP_ADDI, 6'h00, 1, 1, 0, 2, S_ADDI, S_EXC, S_FETCH, S_FETCH, S_FETCH);
    runInstr(0, 8,  OP_LW, 6'h2b, 0, 0, 0, 5, S_REF_MEM, S_LOAD, S_LOAD_WAIT, S_LOAD_WAIT, S_END_REF_MEM);
    runInstr(0, 9,  OP_SW, 6'h00, 0, 0, 0, 4, S_REF_MEM, S_STORE, S_STORE_WAIT, S_STORE_WAIT, S_FETCH);
    runInstr(0, 10, OP_BEQ, 6'h00, 0, 0, 0, 1, S_BEQ, S_FETCH, S_FETCH, S_FETCH, S_FETCH);
    runInstr(0, 11, OP_BNE, 6'h00, 0, 0, 0, 1, S_BNE, S_FETCH, S_FETCH, S_FETCH, S_FETCH);
    runInstr(0, 12, OP_J, 6'h00, 0, 0, 0, 1, S_JUMP, S_FETCH, S_FETCH, S_FETCH, S_FETCH);
    runInstr(0, 13, OP_LUI, 6'h00, 0, 0, 0, 1, S_LUI, S_FETCH, S_FETCH, S_FETCH, S_FETCH);
    runInstr(0, 14, OP_RTYPE, FN_NOP, 0, 0, 0, 1, S_NOP, S_FETCH, S_FETCH, S_FETCH, S_FETCH);
    runInstr(0, 15, 6'h3f, 6'h00, 1, 0, 0, 1, S_EXC, S_FETCH, S_FETCH, S_FETCH, S_FETCH);
    runInstr(0, 16, OP_RTYPE, 6'h3f, 0, 0, 0, 1, S_EXC, S_FETCH, S_FETCH, S_FETCH, S_FETCH);
    runInstr(0, 17, 6'h03, 6'h20, 0, 0, 0, 1, S_EXC, S_FETCH, S_FETCH, S_FETCH, S_FETCH);
    // reset lands in the second LOAD_WAIT cycle
    runInstr(0, 18, OP_LW, 6'h2b, 0, 0, 7, 5, S_REF_MEM, S_LOAD, S_LOAD_WAIT, S_LOAD_WAIT, S_END_REF_MEM);
    resetCheck(0, 18);
    runInstr(0, 19, OP_RTYPE, FN_OR, 0, 0, 0, 2, S_CLASSE_R, S_WRITE_RD, S_FETCH, S_FETCH, S_FETCH);
    // BREAK held for 22 cycles, then released only by reset
    runInstr(0, 20, OP_RTYPE, FN_BREAK, 0, 0, 26, 1, S_BREAK, S_FETCH, S_FETCH, S_FETCH, S_FETCH);
    resetCheck(0, 20);
    resetV[0] = 1'b0;

    // MEM_WAIT = 0
    resetCheck(1, 21);
    runInstr(1, 22, OP_LW, 6'h2b, 0, 0, 0, 3, S_REF_MEM, S_LOAD, S_END_REF_MEM, S_FETCH, S_FETCH);
    runInstr(1, 23, OP_SW, 6'h23, 0, 0, 0, 2, S_REF_MEM, S_STORE, S_FETCH, S_FETCH, S_FETCH);
    runInstr(1, 24, OP_RTYPE, FN_ADD, 0, 0, 0, 2, S_CLASSE_R, S_WRITE_RD, S_FETCH, S_FETCH, S_FETCH);
    runInstr(1, 25, OP_BEQ, 6'h00, 0, 0, 0, 1, S_BEQ, S_FETCH, S_FETCH, S_FETCH, S_FETCH);
    runInstr(1, 26, OP_ADDI, 6'h00, 1, 1, 0, 2, S_ADDI, S_EXC, S_FETCH, S_FETCH, S_FETCH);
    runInstr(1, 27, OP_BNE, 6'h00, 0, 0, 0, 1, S_BNE, S_FETCH, S_FETCH, S_FETCH, S_FETCH);

    for (int d = 0; d < 2; d++) begin
      nChecks++;
      if (sb[d].size() != 0) begin
        nFails++;
        $display("FAIL d%0d scoreboard drain: got %0d pending want 0", d, sb[d].size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/unidade_controle_mc.md
# unidade_controle_mc

Parametrised multicycle control unit for the MIPS-subset datapath, with configurable memory wait states, an extended instruction set (ADDI, SLT-class R-type), and precise exceptions for invalid opcodes and arithmetic overflow. It sits between the instruction register/ALU flags and every write-enable and mux select of the datapath. It drives EPC/cause capture and a sticky halt on BREAK.

## Interface
- MEM_WAIT, 1: memory latency in extra cycles inserted after every memory access; 0..15, 0 removes the wait states.
- EXC_VECTOR_SEL, 2'b11: OrigPC code that selects the exception vector in the PC mux.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- OPcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- Overflow  in  1  ALU overflow flag, combinational, valid in CLASSE_R/ADDI cycles.
- EscreveMem, EscrevePC, EscrevePCCondEQ, EscrevePCCondNE, EscreveReg, EscreveIR, EscreveMDR, EscreveAluOut, EscreveEPC, EscreveCausa  out  1 each  register/memory write enables.
- IouD, RegDst, OrigAALU  out  1 each  mux selects.
- OrigPC, MemparaReg, OrigBALU, OpALU  out  2 each  mux selects / ALU op class.
- Causa  out  1  exception cause: 0 = invalid opcode, 1 = overflow.
- Halted  out  1  high while in BREAK.
- State  out  6  current state encoding, for debug.

## Operation
- States: FETCH, FETCH_WAIT, IR_WRITE, CLASSE_R, WRITE_RD, ADDI, ADDI_WB, REF_MEM, LOAD, LOAD_WAIT, END_REF_MEM, STORE, STORE_WAIT, BEQ, BNE, LUI, JUMP, NOP, BREAK, EXC.
- FETCH: IouD=0, OrigAALU=0, OrigBALU=01, OpALU=00, OrigPC=00, EscrevePC=1. Goes to FETCH_WAIT if MEM_WAIT>0, else IR_WRITE.
- FETCH_WAIT: all enables 0. Stays MEM_WAIT cycles, counted by an internal down-counter loaded on entry.
- IR_WRITE: EscreveIR=1, EscreveAluOut=1, OrigBALU=11 (branch target precompute). Decodes the IR inputs this cycle:
  - opcode 0: funct 0x0 -> NOP, 0x0d -> BREAK, {0x20,0x22,0x24,0x25,0x2a} -> CLASSE_R, anything else -> EXC with Causa=0.
  - 0x2 -> JUMP; 0x4 -> BEQ; 0x5 -> BNE; 0x8 -> ADDI; 0xf -> LUI; 0x23/0x2b -> REF_MEM.
  - Any other opcode -> EXC with Causa=0.
- REF_MEM: OrigAALU=1, OrigBALU=10, EscreveAluOut=1. Branches on the latched opcode (0x23 -> LOAD, 0x2b -> STORE), never on funct.
- LOAD: IouD=1, EscreveMDR=1; then LOAD_WAIT (MEM_WAIT cycles, EscreveMDR held 1), then END_REF_MEM.
- END_REF_MEM: MemparaReg=01, RegDst=0, EscreveReg=1.
- STORE: IouD=1, EscreveMem=1; then STORE_WAIT (EscreveMem=0), then FETCH.
- CLASSE_R: OrigAALU=1, OrigBALU=00, OpALU=10, EscreveAluOut=1. If Overflow and funct ∈ {0x20,0x22} -> EXC with Causa=1, else WRITE_RD.
- WRITE_RD: RegDst=1, EscreveReg=1, MemparaReg=00.
- ADDI: OrigAALU=1, OrigBALU=10, OpALU=00, EscreveAluOut=1. Overflow -> EXC with Causa=1, else ADDI_WB.
- ADDI_WB: RegDst=0, EscreveReg=1, MemparaReg=00.
- BEQ/BNE: OrigAALU=1, OpALU=01, OrigPC=01, EscrevePCCondEQ/NE=1.
- LUI: EscreveReg=1, MemparaReg=10.
- JUMP: OrigPC=10, EscrevePC=1.
- EXC: OrigAALU=0, OrigBALU=01, OpALU=01, so EPC captures PC−4. Asserts EscreveEPC=1, EscreveCausa=1, OrigPC=EXC_VECTOR_SEL, EscrevePC=1. Causa is held from the decision cycle through EXC.
- BREAK: Halted=1, all enables 0, self-loop. Exits only on reset.
- Every state not listed as self-looping returns to FETCH. An unreachable encoding goes to FETCH with all enables 0.
- Any output not named for a state is 0 in that state.

## Timing
- Reset (reset=0): asynchronously State=FETCH. All enables, Halted and Causa are 0, all selects are 00. The first rising edge after release performs the FETCH outputs.
- Outputs are Moore: a function of state, plus Causa from a register.
- Cycle counts, with W=MEM_WAIT:
  - R-type: 4+W.
  - ADDI: 4+W.
  - LW: 5+2W.
  - SW: 4+2W.
  - BEQ/BNE/J/LUI/NOP: 3+W.
  - Exception: 4+W (R/ADDI) or 3+W (invalid opcode).
- Reset asserted mid-instruction aborts it with no further enable pulses.

## Structure
- Package ctrl_pkg holds:
  - the state enum (6-bit);
  - opcode/funct localparams;
  - the 2-bit encodings for OrigPC, MemparaReg, OrigBALU and OpALU.
- Sub-module mem_wait_cnt: loadable down-counter with done flag, width $clog2(MEM_WAIT+1) (minimum 1). It is shared by FETCH_WAIT, LOAD_WAIT and STORE_WAIT.

## Test plan
- MEM_WAIT=2, OPcode=0, funct=0x20, Overflow=0 -> states FETCH, FETCH_WAIT×2, IR_WRITE, CLASSE_R, WRITE_RD, FETCH. EscreveReg=1 with RegDst=1 for exactly 1 cycle.
- MEM_WAIT=0, OPcode=0x23 -> LOAD, END_REF_MEM in 5 cycles; OPcode=0x2b -> EscreveMem high exactly 1 cycle, total 4 cycles. funct value is irrelevant (drive 0x2b with LW).
- OPcode=0x8, Overflow=1 in ADDI -> EXC with Causa=1, EscreveEPC=1, OpALU=01, OrigPC=11. No EscreveReg pulse.
- OPcode=0x3f -> EXC directly after IR_WRITE, Causa=0; then FETCH.
- OPcode=0, funct=0x0d -> BREAK, Halted=1 for 20+ cycles with all enables 0. Reset low clears Halted immediately without waiting for a clock edge.
- reset pulsed low during LOAD_WAIT (MEM_WAIT=3) -> State=FETCH and EscreveMDR=0 immediately. Clean fetch follows after release.
